// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch front end: default bus widths,
// the default PC increment and the prefetch entry record.
package cpu_pkg;

  // Widths of the core's register and instruction buses
  localparam int REG_BUS_W   = 32;
  localparam int INST_BUS_W  = 32;

  // Fetch front-end defaults, tied to the bus widths above
  localparam int ADDR_W_DEF  = REG_BUS_W;
  localparam int DATA_W_DEF  = INST_BUS_W;
  localparam int PC_STEP_DEF = 4;

  // One prefetch slot: fetch address, returned instruction, data-present flag
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] inst;
    logic                  filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_ring.sv
// In-order reservation ring for the prefetch buffer. A slot is reserved
// (with its PC) when a fetch is issued, receives its instruction when the
// ROM answers, and is released when ID consumes it. flush empties the ring.
module fetch_ring
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc,
  input  logic [ADDR_W-1:0] alloc_pc,
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              pop,
  output logic              head_valid,
  output logic [ADDR_W-1:0] head_pc,
  output logic [DATA_W-1:0] head_inst,
  output logic [CNT_W-1:0]  alloc_cnt,
  output logic [CNT_W-1:0]  unfilled
);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic [DEPTH-1:0]  filled;
  logic [PTR_W-1:0]  alloc_ptr;
  logic [PTR_W-1:0]  fill_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Slot payload storage; contents are qualified by the filled flags, so no reset
  always_ff @(posedge clk) begin
    if (alloc) pc_mem[alloc_ptr] <= alloc_pc;
    if (fill)  inst_mem[fill_ptr] <= fill_data;
  end

  // Per-slot filled flag: set on response, cleared on pop or flush
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (rst || flush)
        filled[gi] <= 1'b0;
      else if (fill && (fill_ptr == PTR_W'(gi)))
        filled[gi] <= 1'b1;
      else if (pop && (rd_ptr == PTR_W'(gi)))
        filled[gi] <= 1'b0;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); counts move by net delta
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      alloc_cnt <= '0;
      unfilled  <= '0;
    end else begin
      if (alloc) alloc_ptr <= alloc_ptr + 1'b1;
      if (fill)  fill_ptr  <= fill_ptr + 1'b1;
      if (pop)   rd_ptr    <= rd_ptr + 1'b1;
      alloc_cnt <= alloc_cnt + CNT_W'(alloc) - CNT_W'(pop);
      unfilled  <= unfilled + CNT_W'(alloc) - CNT_W'(fill);
    end
  end

  assign head_valid = (alloc_cnt != '0) && filled[rd_ptr];
  assign head_pc    = pc_mem[rd_ptr];
  assign head_inst  = inst_mem[rd_ptr];

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: PC generator, ROM request/response handshake
// and a DEPTH-entry in-order prefetch buffer feeding the ID stage, with ID
// stall and branch redirect/flush. Responses for fetches issued before a
// redirect are counted in drop_cnt and discarded as they return.
// Optional build macro IF_PREFETCH_PERF_EN adds saturating stall, flush and
// drop counters on perf_stall_o / perf_flush_o / perf_drop_o.
module if_prefetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = PC_STEP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic              rom_ready_i,
  input  logic              rom_valid_i,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [DATA_W-1:0] id_inst_o,
  input  logic              id_ready_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i
`ifdef IF_PREFETCH_PERF_EN
  ,
  output logic [31:0]       perf_stall_o,
  output logic [31:0]       perf_flush_o,
  output logic [31:0]       perf_drop_o
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  alloc_cnt;
  logic [CNT_W-1:0]  unfilled;
  logic [SUM_W-1:0]  occupancy;
  logic              head_valid;
  logic [ADDR_W-1:0] head_pc;
  logic [DATA_W-1:0] head_inst;
  logic              issue;
  logic              resp_live;
  logic              resp_drop;
  logic              fill;
  logic              pop;

  // Slots still owed a response (kept or to be dropped) bound new issues
  assign occupancy  = SUM_W'(alloc_cnt) + SUM_W'(drop_cnt);
  assign rom_ce_o   = !rst && !redirect_i && (occupancy < SUM_W'(DEPTH));
  assign rom_addr_o = pc;
  assign issue      = rom_ce_o && rom_ready_i;

  // A response with nothing outstanding is ignored entirely
  assign resp_live  = rom_valid_i && ((drop_cnt != '0) || (unfilled != '0));
  assign resp_drop  = resp_live && (drop_cnt != '0);
  assign fill       = resp_live && (drop_cnt == '0) && !redirect_i;

  assign id_valid_o = head_valid && !redirect_i;
  assign pop        = id_valid_o && id_ready_i;
  assign id_pc_o    = head_valid ? head_pc : '0;
  assign id_inst_o  = head_valid ? head_inst : '0;

  fetch_ring #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ring (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_i),
    .alloc      (issue),
    .alloc_pc   (pc),
    .fill       (fill),
    .fill_data  (rom_data_i),
    .pop        (pop),
    .head_valid (head_valid),
    .head_pc    (head_pc),
    .head_inst  (head_inst),
    .alloc_cnt  (alloc_cnt),
    .unfilled   (unfilled)
  );

  // PC and drop accounting; a redirect turns every unfilled slot into a drop
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_i) begin
      pc       <= redirect_pc_i;
      drop_cnt <= drop_cnt + unfilled - CNT_W'(resp_live);
    end else begin
      if (issue)     pc       <= pc + ADDR_W'(PC_STEP);
      if (resp_drop) drop_cnt <= drop_cnt - 1'b1;
    end
  end

  // The ROM must never answer when nothing is outstanding
  a_no_orphan_resp : assert property (@(posedge clk) disable iff (rst)
    rom_valid_i |-> ((drop_cnt != '0) || (unfilled != '0)));

`ifdef IF_PREFETCH_PERF_EN
  logic [2:0]       perf_evt;
  logic [2:0][31:0] perf_cnt;

  // Event 0: ID stall, 1: redirect cycle, 2: discarded response
  assign perf_evt = {(redirect_i ? resp_live : resp_drop), redirect_i,
                     (id_valid_o && !id_ready_i)};

  for (genvar gi = 0; gi < 3; gi++) begin : g_perf
    // Saturating event counter
    always_ff @(posedge clk) begin
      if (rst)
        perf_cnt[gi] <= '0;
      else if (perf_evt[gi] && (perf_cnt[gi] != '1))
        perf_cnt[gi] <= perf_cnt[gi] + 32'd1;
    end
  end

  assign perf_stall_o = perf_cnt[0];
  assign perf_flush_o = perf_cnt[1];
  assign perf_drop_o  = perf_cnt[2];
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: free-run latency, ID back-pressure, ROM
// back-pressure, redirect with outstanding fetches, redirect against a
// valid head, and PC wrap (second instance with RESET_PC near the top).
module tb_if_prefetch;

  logic        clk;
  logic        rst;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic        rom_ready_i;
  logic        rom_valid_i;
  logic [31:0] rom_data_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  logic        ce2;
  logic [31:0] addr2;
  logic        idv2;
  logic [31:0] idpc2;
  logic [31:0] idinst2;

`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] perf_stall_o, perf_flush_o, perf_drop_o;
  logic [31:0] perf_stall2, perf_flush2, perf_drop2;
`endif

  int checks;
  int errors;
  int lat;
  logic [31:0] q_addr[$];
  int          q_age[$];

  if_prefetch dut (
    .clk           (clk),
    .rst           (rst),
    .rom_ce_o      (rom_ce_o),
    .rom_addr_o    (rom_addr_o),
    .rom_ready_i   (rom_ready_i),
    .rom_valid_i   (rom_valid_i),
    .rom_data_i    (rom_data_i),
    .id_valid_o    (id_valid_o),
    .id_pc_o       (id_pc_o),
    .id_inst_o     (id_inst_o),
    .id_ready_i    (id_ready_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i)
`ifdef IF_PREFETCH_PERF_EN
    ,
    .perf_stall_o  (perf_stall_o),
    .perf_flush_o  (perf_flush_o),
    .perf_drop_o   (perf_drop_o)
`endif
  );

  if_prefetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk           (clk),
    .rst           (rst),
    .rom_ce_o      (ce2),
    .rom_addr_o    (addr2),
    .rom_ready_i   (rom_ready_i),
    .rom_valid_i   (rom_valid_i),
    .rom_data_i    (rom_data_i),
    .id_valid_o    (idv2),
    .id_pc_o       (idpc2),
    .id_inst_o     (idinst2),
    .id_ready_i    (id_ready_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i)
`ifdef IF_PREFETCH_PERF_EN
    ,
    .perf_stall_o  (perf_stall2),
    .perf_flush_o  (perf_flush2),
    .perf_drop_o   (perf_drop2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word the ROM returns for an address
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #2;
  endtask

  // One clock: sample the handshake, take the edge, then advance the ROM model
  task automatic cyc();
    logic        acc;
    logic [31:0] a;
    logic        r;
    acc = rom_ce_o & rom_ready_i;
    a   = rom_addr_o;
    r   = rst;
    @(posedge clk);
    #1;
    if (r) begin
      q_addr.delete();
      q_age.delete();
    end else begin
      if (rom_valid_i && (q_addr.size() > 0)) begin
        void'(q_addr.pop_front());
        void'(q_age.pop_front());
      end
      foreach (q_age[k]) q_age[k]++;
      if (acc) begin
        q_addr.push_back(a);
        q_age.push_back(1);
      end
    end
    rom_valid_i = (q_addr.size() > 0) ? (q_age[0] >= lat) : 1'b0;
    rom_data_i  = rom_valid_i ? rom_word(q_addr[0]) : 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_pc;
    int          n;
    logic        found;
    checks = 0;
    errors = 0;
    lat = 1;
    rst = 1'b1;
    rom_ready_i = 1'b1;
    rom_valid_i = 1'b0;
    rom_data_i = '0;
    id_ready_i = 1'b1;
    redirect_i = 1'b0;
    redirect_pc_i = '0;

    // ---- reset state ----
    cyc();
    cyc();
    settle();
    chk("rst_ce", rom_ce_o, 0);
    chk("rst_addr", rom_addr_o, 0);
    chk("rst_idv", id_valid_o, 0);
    chk("rst_idpc", id_pc_o, 0);
    chk("rst_idinst", id_inst_o, 0);
    chk("rst_addr2", addr2, 32'hFFFF_FFF8);

    // ---- free run, latency 1 ----
    cyc();
    rst = 1'b0;
    settle();
    chk("c1_ce", rom_ce_o, 1);
    chk("c1_addr", rom_addr_o, 0);
    chk("c1_ce2", ce2, 1);
    cyc();
    settle();
    chk("c2_idv", id_valid_o, 0);
    chk("c2_addr", rom_addr_o, 4);
    cyc();
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("run_idv", id_valid_o, 1);
      chk("run_pc", id_pc_o, 32'(i * 4));
      chk("run_inst", id_inst_o, rom_word(32'(i * 4)));
      chk("wrap_idv", idv2, 1);
      chk("wrap_pc", idpc2, 32'hFFFF_FFF8 + 32'(i * 4));
      if (i == 0) chk("wrap_inst", idinst2, rom_word(32'h0));
      cyc();
    end

    // ---- mid-run reset, then ID stall from reset ----
    rst = 1'b1;
    id_ready_i = 1'b0;
    settle();
    cyc();
    rst = 1'b0;
    settle();
    chk("mrst_idv", id_valid_o, 0);
    chk("mrst_addr", rom_addr_o, 0);
    cyc();
    cyc();
    settle();
    chk("stall_c3_idv", id_valid_o, 1);
    chk("stall_c3_pc", id_pc_o, 0);
    cyc();
    cyc();
    settle();
    chk("full_ce", rom_ce_o, 0);
    chk("full_addr", rom_addr_o, 16);
    cyc();
    cyc();
    settle();
    chk("full_ce_hold", rom_ce_o, 0);
    cyc();
    id_ready_i = 1'b1;
    settle();
    chk("rel_pc0", id_pc_o, 0);
    chk("rel_ce_blocked", rom_ce_o, 0);
`ifdef IF_PREFETCH_PERF_EN
    chk("perf_stall", perf_stall_o, 5);
`endif
    cyc();
    settle();
    chk("rel_pc4", id_pc_o, 4);
    chk("rel_ce", rom_ce_o, 1);
    chk("rel_addr", rom_addr_o, 16);
    cyc();
    settle();
    chk("rel_pc8", id_pc_o, 8);
    cyc();
    settle();
    chk("rel_pc12", id_pc_o, 12);
    cyc();
    settle();
    chk("rel_idv16", id_valid_o, 1);
    chk("rel_pc16", id_pc_o, 16);
    cyc();

    // ---- ROM not ready for 3 cycles mid-stream ----
    exp_pc = 32'd20;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      rom_ready_i = (i >= 3);
      settle();
      if (i < 3) chk("rom_hold_addr", rom_addr_o, 32);
      if (id_valid_o) begin
        chk("stream_pc", id_pc_o, exp_pc);
        chk("stream_inst", id_inst_o, rom_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n++;
      end
      cyc();
    end
    rom_ready_i = 1'b1;
    chk("stream_cnt", 32'(n), 10);

    // ---- redirect with two fetches outstanding, latency 3 ----
    rst = 1'b1;
    lat = 3;
    settle();
    cyc();
    rst = 1'b0;
    settle();
    cyc();
    cyc();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    settle();
    chk("redir_ce", rom_ce_o, 0);
    chk("redir_idv", id_valid_o, 0);
    cyc();
    redirect_i = 1'b0;
    settle();
    chk("post_redir_ce", rom_ce_o, 1);
    chk("post_redir_addr", rom_addr_o, 32'h100);
    chk("drop_idv_c4", id_valid_o, 0);
    cyc();
    settle();
    chk("drop_idv_c5", id_valid_o, 0);
    chk("post_redir_addr2", rom_addr_o, 32'h104);
    cyc();
    settle();
    chk("drop_idv_c6", id_valid_o, 0);
    cyc();
    settle();
    chk("drop_idv_c7", id_valid_o, 0);
    cyc();
    settle();
    chk("redir_first_idv", id_valid_o, 1);
    chk("redir_first_pc", id_pc_o, 32'h100);
    chk("redir_first_inst", id_inst_o, rom_word(32'h100));
`ifdef IF_PREFETCH_PERF_EN
    chk("perf_drop_2", perf_drop_o, 2);
    chk("perf_flush_1", perf_flush_o, 1);
`endif
    cyc();
    settle();
    chk("redir_second_pc", id_pc_o, 32'h104);
    cyc();

    // ---- redirect while head is valid and ID is ready ----
    settle();
    chk("pre_redir_idv", id_valid_o, 1);
    chk("pre_redir_pc", id_pc_o, 32'h108);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h200;
    #1;
    chk("void_head_idv", id_valid_o, 0);
    cyc();
    redirect_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      settle();
      if (id_valid_o) begin
        found = 1'b1;
        chk("after_void_pc", id_pc_o, 32'h200);
        chk("after_void_inst", id_inst_o, rom_word(32'h200));
        break;
      end
      cyc();
    end
    chk("after_void_found", found, 1);
`ifdef IF_PREFETCH_PERF_EN
    chk("perf_drop_4", perf_drop_o, 4);
    chk("perf_flush_2", perf_flush_o, 2);
    chk("perf_flush2_2", perf_flush2, 2);
    chk("perf_stall2_0", perf_stall2, 0);
    chk("perf_drop2_4", perf_drop2, 4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
